thread_context_unit: RTL and testbench
======================================

Name: thread_context_unit

Overview:
- N-thread program-counter and thread-scheduling block for the fine-grained interleaved fetch stage.
- Holds one PC per hardware thread and a per-thread run/halt state.
- Picks the next runnable thread round-robin every cycle, presents its PC to fetch, and advances it on a fetch handshake.
- Applies taken-branch redirects, halts and restarts that arrive from the EX/WB stage.

Parameters:
- NUM_THREADS, 4: hardware thread count, 2..16.
- TID_W, 2: thread-id width; must equal ceil(log2(NUM_THREADS)).
- PC_W, 8: PC width in bits; all PC arithmetic is modulo 2^PC_W.
- PC_STEP, 2: PC increment per fetched instruction.
- RESET_BASE, 0: reset PC of thread 0.
- RESET_STRIDE, 100: reset PC of thread t = (RESET_BASE + t*RESET_STRIDE) mod 2^PC_W.
- RESET_ACTIVE, all ones (NUM_THREADS bits): per-thread run state after reset; 1 = active.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- fetch_valid  out  1  a runnable thread is presented this cycle.
- fetch_ready  in  1  fetch stage accepts the presented thread/PC.
- fetch_thread_id  out  TID_W  selected thread.
- fetch_pc  out  PC_W  current PC of the selected thread.
- thread_stall  in  NUM_THREADS  per-thread temporary stall; a stalled thread is not eligible.
- branch_taken  in  1  redirect request.
- branch_thread_id  in  TID_W  thread being redirected.
- branch_target  in  PC_W  new PC.
- halt_valid  in  1  halt request.
- halt_thread_id  in  TID_W  thread to halt.
- start_valid  in  1  start/restart request.
- start_thread_id  in  TID_W  thread to start.
- start_pc  in  PC_W  PC loaded on start.
- thread_active  out  NUM_THREADS  per-thread run state.
- all_halted  out  1  high when thread_active == 0.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - pc[t] = RESET_BASE + t*RESET_STRIDE mod 2^PC_W.
  - thread_active = RESET_ACTIVE.
  - rr_ptr = NUM_THREADS-1, so thread 0 is considered first.
  - While rst is high: fetch_valid=0, fetch_thread_id=0, fetch_pc=pc[0].
- Eligibility: eligible[t] = thread_active[t] & ~thread_stall[t].
- Selection is combinational from registered state plus thread_stall:
  - Search from rr_ptr+1 upward, wrapping at NUM_THREADS-1 -> 0; the first eligible thread is selected.
  - fetch_valid = |eligible.
  - fetch_thread_id = selected thread, or 0 when fetch_valid=0.
  - fetch_pc = pc[fetch_thread_id].
- Handshake (fetch_valid & fetch_ready):
  - pc[sel] <= pc[sel] + PC_STEP, wrapping modulo 2^PC_W.
  - rr_ptr <= sel.
- No handshake: rr_ptr holds. The selection stays stable unless thread_stall or thread_active changes.
- Redirect: branch_taken sets pc[branch_thread_id] <= branch_target next cycle. There is no valid qualifier; branch_taken alone is sufficient.
- Halt: halt_valid clears thread_active[halt_thread_id]. The thread's PC is unchanged except by a same-cycle redirect.
- Start: start_valid sets thread_active[start_thread_id] and pc[start_thread_id] <= start_pc. Starting an already-active thread acts as a redirect.
- Priority per thread, same cycle, highest first:
  - PC: start > branch > fetch increment.
  - Run state: start > halt.
- Different threads in the same cycle: all events apply independently.
- Latency: every update is visible on fetch_pc/thread_active one cycle after the triggering edge. There is no combinational bypass.
  - If a redirected thread handshakes in the same cycle, the PC fetched that cycle is wrong-path; squashing it is downstream's responsibility.
- Out-of-range thread ids (>= NUM_THREADS) on branch, halt or start are ignored.
- all_halted: fetch_valid=0 and all PCs frozen until a start or reset.

Test Plan:
1. Reset with NUM_THREADS=4, PC_W=8, fetch_ready=1 held -> reset PCs 0, 100, 200, 44 (300 mod 256). Fetch sequence is T0@0, T1@100, T2@200, T3@44, T0@2, T1@102, ...
2. Stall and backpressure: thread_stall=4'b0010 for 3 cycles -> T1 skipped, order T0, T2, T3, T0. With fetch_ready=0 for 2 cycles on T2 -> T2/pc held, T2's PC not incremented, rr_ptr unchanged.
3. Wrap: start T3 with start_pc=254, fetch it twice -> fetch_pc 254 then 0.
4. Simultaneous events: branch_taken T0->0x40 while T0 handshakes -> next T0 PC = 0x40, not +2. start T1@0x10 together with halt T1 and branch T1->0x80 -> T1 active, PC 0x10.
5. Halt all: halt T0..T3 on successive cycles -> thread_active reaches 0, all_halted=1, fetch_valid=0. Then start T2@0x20 -> next cycle fetch_valid=1, T2@0x20.
6. Reset mid-operation: assert rst asynchronously between edges during active fetch -> outputs return immediately to reset values, fetch_valid=0. After release, the sequence from scenario 1 repeats.

Source files
------------

// File: rtl/thread_context_unit.sv
// thread_context_unit
//   Per-thread PC / run-state holder and round-robin thread picker for an
//   interleaved fetch stage.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     fetch_valid/ready        fetch handshake for the selected thread
//     fetch_thread_id/pc       selected thread and its current PC
//     thread_stall             per-thread temporary ineligibility
//     branch_*                 taken-branch redirect from EX/WB
//     halt_*                   halt request from EX/WB
//     start_*                  start/restart request (loads PC, sets active)
//     thread_active            per-thread run state
//     all_halted               no thread is active

// Per-thread PC and run-state register with local update priority.
module thread_ctx_lane #(
    parameter int              PC_W    = 8,
    parameter int              PC_STEP = 2,
    parameter logic [PC_W-1:0] RST_PC  = '0,
    parameter logic            RST_ACT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_inc,
    input  logic            branch_hit,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt_hit,
    input  logic            start_hit,
    input  logic [PC_W-1:0] start_pc,
    output logic [PC_W-1:0] pc,
    output logic            active
);
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            active_q, active_d;

    always_comb begin
        pc_d = pc_q;
        if (start_hit)       pc_d = start_pc;
        else if (branch_hit) pc_d = branch_target;
        else if (fetch_inc)  pc_d = pc_q + STEP;

        active_d = active_q;
        if (start_hit)     active_d = 1'b1;
        else if (halt_hit) active_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RST_PC;
            active_q <= RST_ACT;
        end else begin
            pc_q     <= pc_d;
            active_q <= active_d;
        end
    end

    assign pc     = pc_q;
    assign active = active_q;
endmodule

module thread_context_unit #(
    parameter int                     NUM_THREADS  = 4,
    parameter int                     TID_W        = 2,
    parameter int                     PC_W         = 8,
    parameter int                     PC_STEP      = 2,
    parameter int                     RESET_BASE   = 0,
    parameter int                     RESET_STRIDE = 100,
    parameter logic [NUM_THREADS-1:0] RESET_ACTIVE = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [TID_W-1:0]       fetch_thread_id,
    output logic [PC_W-1:0]        fetch_pc,
    input  logic [NUM_THREADS-1:0] thread_stall,
    input  logic                   branch_taken,
    input  logic [TID_W-1:0]       branch_thread_id,
    input  logic [PC_W-1:0]        branch_target,
    input  logic                   halt_valid,
    input  logic [TID_W-1:0]       halt_thread_id,
    input  logic                   start_valid,
    input  logic [TID_W-1:0]       start_thread_id,
    input  logic [PC_W-1:0]        start_pc,
    output logic [NUM_THREADS-1:0] thread_active,
    output logic                   all_halted
);
    typedef struct packed {
        logic             vld;
        logic [TID_W-1:0] tid;
        logic [PC_W-1:0]  pc;
    } ctl_req_t;

    ctl_req_t br_req, ht_req, st_req;
    assign br_req = '{vld: branch_taken, tid: branch_thread_id, pc: branch_target};
    assign ht_req = '{vld: halt_valid,   tid: halt_thread_id,   pc: '0};
    assign st_req = '{vld: start_valid,  tid: start_thread_id,  pc: start_pc};

    logic [NUM_THREADS-1:0][PC_W-1:0] pc_all;
    logic [NUM_THREADS-1:0]           active_all;
    logic [NUM_THREADS-1:0]           eligible;
    logic [TID_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [TID_W-1:0]                 sel;
    logic                             any_elig;
    logic                             hs;

    assign eligible = active_all & ~thread_stall;
    assign any_elig = |eligible;

    // Round-robin search starting just after the last-served thread.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_THREADS;
            if (!found && eligible[idx]) begin
                sel   = TID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Outputs are forced to the idle/thread-0 view while reset is held,
    // even though the reset state itself has runnable threads.
    assign fetch_valid     = any_elig & ~rst;
    assign fetch_thread_id = fetch_valid ? sel : '0;
    assign fetch_pc        = pc_all[fetch_thread_id];
    assign hs              = fetch_valid & fetch_ready;

    assign rr_ptr_d = hs ? sel : rr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= TID_W'(NUM_THREADS - 1);
        else     rr_ptr_q <= rr_ptr_d;
    end

    // Thread-id matches against in-range lanes only, so out-of-range ids
    // fall through without effect.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
        localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_BASE + t * RESET_STRIDE);
        thread_ctx_lane #(
            .PC_W    (PC_W),
            .PC_STEP (PC_STEP),
            .RST_PC  (RST_PC),
            .RST_ACT (RESET_ACTIVE[t])
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .fetch_inc     (hs && (sel == TID_W'(t))),
            .branch_hit    (br_req.vld && (br_req.tid == TID_W'(t))),
            .branch_target (br_req.pc),
            .halt_hit      (ht_req.vld && (ht_req.tid == TID_W'(t))),
            .start_hit     (st_req.vld && (st_req.tid == TID_W'(t))),
            .start_pc      (st_req.pc),
            .pc            (pc_all[t]),
            .active        (active_all[t])
        );
    end

    assign thread_active = active_all;
    assign all_halted    = ~|active_all;
endmodule

// File: tb/tb_thread_context_unit.sv
module tb_thread_context_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_valid, fetch_ready;
    logic [1:0] fetch_thread_id;
    logic [7:0] fetch_pc;
    logic [3:0] thread_stall;
    logic       branch_taken;
    logic [1:0] branch_thread_id;
    logic [7:0] branch_target;
    logic       halt_valid;
    logic [1:0] halt_thread_id;
    logic       start_valid;
    logic [1:0] start_thread_id;
    logic [7:0] start_pc;
    logic [3:0] thread_active;
    logic       all_halted;

    thread_context_unit dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_thread_id(fetch_thread_id), .fetch_pc(fetch_pc),
        .thread_stall(thread_stall),
        .branch_taken(branch_taken), .branch_thread_id(branch_thread_id),
        .branch_target(branch_target),
        .halt_valid(halt_valid), .halt_thread_id(halt_thread_id),
        .start_valid(start_valid), .start_thread_id(start_thread_id),
        .start_pc(start_pc),
        .thread_active(thread_active), .all_halted(all_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] tid;
        logic [7:0] pc;
        logic [3:0] act;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   tag    = 0;

    task automatic chk(input string name, input int tg, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, tg, got, want);
    endtask

    // Monitor: every negedge with a pending expectation compares all outputs.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("fetch_valid", e.tag, 32'(fetch_valid), 32'(e.v));
            chk("fetch_thread_id", e.tag, 32'(fetch_thread_id), 32'(e.tid));
            chk("fetch_pc", e.tag, 32'(fetch_pc), 32'(e.pc));
            chk("thread_active", e.tag, 32'(thread_active), 32'(e.act));
            chk("all_halted", e.tag, 32'(all_halted), 32'(e.act == 4'd0));
        end
    end

    task automatic expect_now(input logic v, input logic [1:0] tid, input logic [7:0] pc, input logic [3:0] act);
        exp_t e;
        e.v = v; e.tid = tid; e.pc = pc; e.act = act; e.tag = tag;
        tag++;
        q.push_back(e);
    endtask

    // Push this cycle's expectation, advance one clock, drop one-shot events.
    task automatic step(input logic v, input logic [1:0] tid, input logic [7:0] pc, input logic [3:0] act);
        expect_now(v, tid, pc, act);
        @(posedge clk); #1;
        branch_taken = 1'b0;
        halt_valid   = 1'b0;
        start_valid  = 1'b0;
    endtask

    task automatic reset_sequence();
        step(1, 0, 8'd0,   4'hF);
        step(1, 1, 8'd100, 4'hF);
        step(1, 2, 8'd200, 4'hF);
        step(1, 3, 8'd44,  4'hF);
        step(1, 0, 8'd2,   4'hF);
        step(1, 1, 8'd102, 4'hF);
        step(1, 2, 8'd202, 4'hF);
        step(1, 3, 8'd46,  4'hF);
    endtask

    initial begin
        rst = 1'b1; fetch_ready = 1'b1; thread_stall = '0;
        branch_taken = 0; branch_thread_id = 0; branch_target = 0;
        halt_valid = 0; halt_thread_id = 0;
        start_valid = 0; start_thread_id = 0; start_pc = 0;
        @(posedge clk); #1;
        step(0, 0, 8'd0, 4'hF);          // held in reset
        rst = 1'b0;

        // 1: reset PCs and round-robin order
        reset_sequence();

        // 2: stall T1 for three cycles, then backpressure on T2
        thread_stall = 4'b0010;
        step(1, 0, 8'd4,   4'hF);
        step(1, 2, 8'd204, 4'hF);
        step(1, 3, 8'd48,  4'hF);
        thread_stall = 4'b0000;
        step(1, 0, 8'd6,   4'hF);
        step(1, 1, 8'd104, 4'hF);
        fetch_ready = 1'b0;
        step(1, 2, 8'd206, 4'hF);
        step(1, 2, 8'd206, 4'hF);
        fetch_ready = 1'b1;
        step(1, 2, 8'd206, 4'hF);
        step(1, 3, 8'd50,  4'hF);

        // 3: start T3 at 254 while only T3 is eligible; PC wraps to 0
        thread_stall = 4'b0111;
        start_valid = 1; start_thread_id = 3; start_pc = 8'd254;
        step(1, 3, 8'd52,  4'hF);        // start beats fetch increment
        step(1, 3, 8'd254, 4'hF);
        step(1, 3, 8'd0,   4'hF);
        thread_stall = 4'b0000;

        // 4: branch during handshake; start+halt+branch on one thread
        branch_taken = 1; branch_thread_id = 0; branch_target = 8'h40;
        step(1, 0, 8'd8, 4'hF);
        start_valid = 1; start_thread_id = 1; start_pc = 8'h10;
        halt_valid = 1; halt_thread_id = 1;
        branch_taken = 1; branch_thread_id = 1; branch_target = 8'h80;
        step(1, 1, 8'd106, 4'hF);
        step(1, 2, 8'd208, 4'hF);
        step(1, 3, 8'd2,   4'hF);
        step(1, 0, 8'h40,  4'hF);
        step(1, 1, 8'h10,  4'hF);

        // 5: halt every thread, then restart T2
        halt_valid = 1; halt_thread_id = 0;
        step(1, 2, 8'd210, 4'b1111);
        halt_valid = 1; halt_thread_id = 1;
        step(1, 3, 8'd4,   4'b1110);
        halt_valid = 1; halt_thread_id = 2;
        step(1, 2, 8'd212, 4'b1100);
        halt_valid = 1; halt_thread_id = 3;
        step(1, 3, 8'd6,   4'b1000);
        step(0, 0, 8'h42,  4'b0000);     // all halted, PCs frozen
        start_valid = 1; start_thread_id = 2; start_pc = 8'h20;
        step(0, 0, 8'h42,  4'b0000);
        step(1, 2, 8'h20,  4'b0100);

        // 6: asynchronous reset between edges during active fetch
        expect_now(0, 0, 8'd0, 4'hF);    // checked at negedge after rst rises
        #2 rst = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 8'd0, 4'hF);
        rst = 1'b0;
        reset_sequence();

        @(posedge clk); #1;
        chk("scoreboard_drained", tag, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
